// File: rtl/clk_div_tick.sv
// Programmable integer clock divider with an end-of-period tick strobe.
// Divisor changes are queued and take effect only at a period boundary.
module clk_div_tick #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             clk_div,
    output logic             tick,
    output logic             running,
    output logic [WIDTH-1:0] div_cur
);

    localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] cur_q;
    logic [WIDTH-1:0] pend_q;
    logic             clk_div_q;
    logic             tick_q;
    logic             running_q;

    logic [WIDTH-1:0] cap_val;
    logic [WIDTH-1:0] new_div;
    logic [WIDTH-1:0] next_phase;
    logic [WIDTH-1:0] next_div;
    logic             wrap;

    always_comb begin
        cap_val    = (div_val < MinDiv) ? MinDiv : div_val;
        // A load on the wrap edge overrides the queued divisor for the new period
        new_div    = load ? cap_val : pend_q;
        wrap       = (phase_q == (cur_q - WIDTH'(1)));
        next_phase = wrap ? '0 : (phase_q + WIDTH'(1));
        next_div   = wrap ? new_div : cur_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            cur_q     <= MinDiv;
            pend_q    <= MinDiv;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (load) begin
                pend_q <= cap_val;
            end
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        cur_q <= cap_val;
                    end
                    // Divisor is always >= 2, so phase 0 is always in the high half
                    if (enable) begin
                        state_q   <= StRun;
                        running_q <= 1'b1;
                        phase_q   <= '0;
                        clk_div_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (enable) begin
                        phase_q   <= next_phase;
                        cur_q     <= next_div;
                        clk_div_q <= (next_phase < (next_div >> 1));
                        tick_q    <= (next_phase == (next_div - WIDTH'(1)));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;
    assign running = running_q;
    assign div_cur = cur_q;

endmodule

// File: tb/tb_clk_div_tick.sv
// Directed self-checking bench for clk_div_tick: division, clamping, reloads,
// freeze and asynchronous reset.
module tb_clk_div_tick;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] div_val;
    logic       clk_div;
    logic       tick;
    logic       running;
    logic [7:0] div_cur;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_tick #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .div_val (div_val),
        .clk_div (clk_div),
        .tick    (tick),
        .running (running),
        .div_cur (div_cur)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ecd, input logic etick,
                              input logic erun, input logic [7:0] ecur);
        check_val($sformatf("%s.clk_div", tag), {31'd0, clk_div}, {31'd0, ecd});
        check_val($sformatf("%s.tick", tag), {31'd0, tick}, {31'd0, etick});
        check_val($sformatf("%s.running", tag), {31'd0, running}, {31'd0, erun});
        check_val($sformatf("%s.div_cur", tag), {24'd0, div_cur}, {24'd0, ecur});
    endtask

    // One rising edge, then sample 1 time unit later
    task automatic step(input string tag, input logic ecd, input logic etick,
                        input logic erun, input logic [7:0] ecur);
        @(posedge clk);
        #1;
        check_outs(tag, ecd, etick, erun, ecur);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        load   = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] cd_pat;
        logic [7:0] tk_pat;

        reset   = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        div_val = 8'd0;
        #3;
        check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 8'd2);
        #4;
        reset = 1'b0;

        // Load in IDLE updates div_cur on the same edge
        load    = 1'b1;
        div_val = 8'd4;
        step("idle_load", 1'b0, 1'b0, 1'b0, 8'd4);
        load   = 1'b0;
        enable = 1'b1;
        cd_pat = 8'b11001100;
        tk_pat = 8'b00010001;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("div4_e%0d", i + 1), cd_pat[7-i], tk_pat[7-i], 1'b1, 8'd4);
        end

        // Odd ratio, loaded together with the enabling edge
        do_reset();
        load    = 1'b1;
        div_val = 8'd3;
        enable  = 1'b1;
        cd_pat  = 8'b10010000;
        tk_pat  = 8'b00100100;
        for (int i = 0; i < 6; i++) begin
            step($sformatf("div3_e%0d", i + 1), cd_pat[7-i], tk_pat[7-i], 1'b1, 8'd3);
            load = 1'b0;
        end

        // Clamp of 1 in IDLE, then clamp of 0 on the enabling edge
        do_reset();
        load    = 1'b1;
        div_val = 8'd1;
        step("clamp1_idle", 1'b0, 1'b0, 1'b0, 8'd2);
        div_val = 8'd0;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step($sformatf("div2_e%0d", i + 1), (i % 2) == 0, (i % 2) == 1, 1'b1, 8'd2);
            load = 1'b0;
        end

        // Mid-run reload: 4 -> 6 captured in phase 1
        do_reset();
        load    = 1'b1;
        div_val = 8'd4;
        enable  = 1'b1;
        step("reld_e1", 1'b1, 1'b0, 1'b1, 8'd4);
        load = 1'b0;
        step("reld_e2", 1'b1, 1'b0, 1'b1, 8'd4);
        load    = 1'b1;
        div_val = 8'd6;
        step("reld_e3", 1'b0, 1'b0, 1'b1, 8'd4);
        load = 1'b0;
        step("reld_e4", 1'b0, 1'b1, 1'b1, 8'd4);
        cd_pat = 8'b11100011;
        tk_pat = 8'b00000100;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("reld_e%0d", i + 5), cd_pat[7-i], tk_pat[7-i], 1'b1, 8'd6);
        end

        // Load coinciding with the wrap edge governs the new period
        do_reset();
        load    = 1'b1;
        div_val = 8'd4;
        enable  = 1'b1;
        step("wrap_e1", 1'b1, 1'b0, 1'b1, 8'd4);
        load = 1'b0;
        step("wrap_e2", 1'b1, 1'b0, 1'b1, 8'd4);
        step("wrap_e3", 1'b0, 1'b0, 1'b1, 8'd4);
        step("wrap_e4", 1'b0, 1'b1, 1'b1, 8'd4);
        load    = 1'b1;
        div_val = 8'd2;
        step("wrap_e5", 1'b1, 1'b0, 1'b1, 8'd2);
        load = 1'b0;
        step("wrap_e6", 1'b0, 1'b1, 1'b1, 8'd2);
        step("wrap_e7", 1'b1, 1'b0, 1'b1, 8'd2);

        // Freeze at phase 1; a load during the freeze is queued, last one wins
        do_reset();
        load    = 1'b1;
        div_val = 8'd4;
        enable  = 1'b1;
        step("frz_e1", 1'b1, 1'b0, 1'b1, 8'd4);
        load = 1'b0;
        step("frz_e2", 1'b1, 1'b0, 1'b1, 8'd4);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load    = (i == 1) || (i == 3);
            div_val = (i == 1) ? 8'd9 : 8'd6;
            step($sformatf("frz_hold%0d", i), 1'b1, 1'b0, 1'b1, 8'd4);
        end
        load   = 1'b0;
        enable = 1'b1;
        step("frz_res_p2", 1'b0, 1'b0, 1'b1, 8'd4);
        step("frz_res_p3", 1'b0, 1'b1, 1'b1, 8'd4);
        step("frz_res_p0", 1'b1, 1'b0, 1'b1, 8'd6);

        // Asynchronous reset between edges during phase 2
        do_reset();
        load    = 1'b1;
        div_val = 8'd4;
        enable  = 1'b1;
        step("ar_e1", 1'b1, 1'b0, 1'b1, 8'd4);
        load = 1'b0;
        step("ar_e2", 1'b1, 1'b0, 1'b1, 8'd4);
        step("ar_e3", 1'b0, 1'b0, 1'b1, 8'd4);
        #2;
        reset = 1'b1;
        #1;
        check_outs("ar_async", 1'b0, 1'b0, 1'b0, 8'd2);
        @(posedge clk);
        #2;
        check_outs("ar_held", 1'b0, 1'b0, 1'b0, 8'd2);
        reset = 1'b0;
        step("ar_rst_p0", 1'b1, 1'b0, 1'b1, 8'd2);
        step("ar_rst_p1", 1'b0, 1'b1, 1'b1, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_div_tick.md
CLK_DIV_TICK -- requirements
Module: clk_div_tick

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the width of the divisor ports and internal phase counter.
REQ-002 Port clk, input, 1, SHALL be the single rising-edge clock; it is the free-running simulation clock output of the team clock generator.
REQ-003 Port reset, input, 1, SHALL be an asynchronous, active-high reset.
REQ-004 Port enable, input, 1, SHALL allow division to advance when high and freeze it when low.
REQ-005 Port load, input, 1, SHALL capture div_val as the pending divisor on a rising edge when high.
REQ-006 Port div_val, input, WIDTH, SHALL be the requested divide ratio N.
REQ-007 Port clk_div, output, 1, SHALL be the divided clock, driven directly from a flop.
REQ-008 Port tick, output, 1, SHALL pulse for one clk cycle on the last cycle of each divided period.
REQ-009 Port running, output, 1, SHALL be high while the block is in state RUN.
REQ-010 Port div_cur, output, WIDTH, SHALL show the divisor governing the current period.

Function
REQ-011 States SHALL be IDLE and RUN only.
- IDLE -> RUN on the first rising edge with enable=1; that edge starts phase 0.
- RUN -> IDLE only on reset.
REQ-012 In RUN, each edge with enable=1 SHALL advance the phase by one: 0..N-1, with N-1 wrapping to 0.
REQ-013 When enable=0, phase, state, clk_div and div_cur SHALL hold, and tick SHALL be 0.
REQ-014 clk_div SHALL be 1 for phases 0..floor(N/2)-1 and 0 for phases floor(N/2)..N-1, so that:
- N=4 gives 2 high / 2 low;
- N=3 gives 1 high / 2 low.
REQ-015 tick SHALL be 1 exactly in phase N-1 while enable=1 in RUN, and 0 otherwise.
REQ-016 A div_val below 2 SHALL be clamped to 2 at capture; values of 2 or more SHALL be taken unmodified.
REQ-017 A load in IDLE SHALL update div_cur on the same edge.
REQ-018 A load in RUN SHALL update only the pending divisor; the pending value SHALL transfer to div_cur at the next phase wrap (N-1 -> 0).
REQ-019 If load coincides with the wrap edge, the newly captured value SHALL govern the period that starts at that edge.
REQ-020 Multiple loads within one period SHALL keep only the last.
REQ-021 Loads SHALL be captured regardless of the enable level.
REQ-022 All outputs SHALL change only on the rising edge of clk or on assertion of reset.
REQ-023 Outputs SHALL be free of combinational glitches.

Reset
REQ-024 While reset=1, the block SHALL hold:
- state=IDLE, phase=0;
- clk_div=0, tick=0, running=0;
- div_cur=2, pending divisor=2.
REQ-025 Reset asserted mid-period SHALL force REQ-024 values immediately, without waiting for a clk edge.
REQ-026 After reset deasserts, the first enabled edge SHALL start phase 0 of a fresh period.

Verification
REQ-027 Basic division: reset, load div_val=4, enable=1 -> clk_div over edges 1..8 = 1,1,0,0,1,1,0,0; tick high at edges 4 and 8; running=1 from edge 1.
REQ-028 Odd ratio and clamp:
- div_val=3 -> clk_div = 1,0,0 repeating.
- div_val=0 or 1 -> div_cur=2; clk_div = 1,0 repeating; tick on every second edge.
REQ-029 Mid-run reload: N=4 running, load div_val=6 at phase 1 -> the period completes with 4 cycles, then 6-cycle periods (3 high / 3 low); div_cur changes to 6 at the wrap edge.
REQ-030 Load on wrap: N=4, load div_val=2 on the phase-3 edge -> the next period is 2 cycles long; div_cur=2 from that edge.
REQ-031 Freeze: N=4, drop enable at phase 1 for 5 edges -> clk_div held at 1, tick=0, phase unchanged; re-enable -> resumes at phase 2.
REQ-032 Async reset: assert reset between clk edges during phase 2 -> outputs go to REQ-024 values at once; after release with enable=1, phase 0 restarts with clk_div=1.
